// File: rtl/drive_sequencer.sv
// drive_sequencer: runs the search, capture and goal direction controllers in
// turn on the shared drive train. There is a motors-off dead-time before each
// phase, a per-phase timeout that leads to a sticky fault, and pause/abort
// handling. Every output comes from a register.
module drive_sequencer #(
    parameter int DEADTIME_CYC = 100_000,
    parameter int TIMEOUT_CYC  = 1_000_000_000,
    parameter int LOOP         = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic [7:0] cmd0,
    input  logic [7:0] cmd1,
    input  logic [7:0] cmd2,
    input  logic       done0,
    input  logic       done1,
    input  logic       done2,
    output logic       en0,
    output logic       en1,
    output logic       en2,
    output logic       FWD_A,
    output logic       FWD_B,
    output logic       BWD_A,
    output logic       BWD_B,
    output logic [1:0] Duty_SelA,
    output logic [1:0] Duty_SelB,
    output logic [1:0] phase,
    output logic       busy,
    output logic       fault,
    output logic       seq_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_RUN, S_HOLD, S_FINISH, S_FAULT
    } state_t;

    localparam logic [31:0] GAP_LAST = DEADTIME_CYC - 1;
    localparam logic [29:0] TMO_LAST = 30'(TIMEOUT_CYC - 1);

    state_t      state_reg, state_next;
    logic [1:0]  phase_reg, phase_next;
    logic [31:0] gap_cnt_reg, gap_cnt_next;
    logic [29:0] tmo_cnt_reg, tmo_cnt_next;
    logic        pend_reg, pend_next;
    logic        start_d1_reg, start_d2_reg;
    logic        done_d1_reg, done_d2_reg;
    logic [7:0]  motor_reg, motor_next;
    logic [2:0]  en_reg, en_next;
    logic        busy_reg, fault_reg, seq_done_reg;

    logic [7:0]  cmd_sel, cmd_safe;
    logic        done_sel, start_rise, done_rise;
    logic        active, active_next;

    assign cmd_sel    = (phase_reg == 2'd0) ? cmd0 : (phase_reg == 2'd1) ? cmd1 : cmd2;
    assign done_sel   = (phase_reg == 2'd0) ? done0 : (phase_reg == 2'd1) ? done1 : done2;
    assign start_rise = start_d1_reg & ~start_d2_reg;
    assign done_rise  = done_d1_reg & ~done_d2_reg;
    assign active      = (state_reg == S_RUN) || (state_reg == S_HOLD);
    assign active_next = (state_next == S_RUN) || (state_next == S_HOLD);

    // Shoot-through guard: if a motor is asked to go both forward and backward,
    // both of its direction lines are dropped. Duty selects are passed as given.
    assign cmd_safe = {cmd_sel[7] & ~cmd_sel[5], cmd_sel[6] & ~cmd_sel[4],
                       cmd_sel[5] & ~cmd_sel[7], cmd_sel[4] & ~cmd_sel[6],
                       cmd_sel[3:0]};

    // Next state and phase, with abort > pause > done rise > timeout.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        pend_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_rise) begin
                    state_next = S_GAP;
                    phase_next = 2'd0;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) state_next = S_RUN;
            end
            S_RUN: begin
                if (pause) begin
                    state_next = S_HOLD;
                    pend_next  = pend_reg | done_rise;
                end else if (done_rise || pend_reg) begin
                    if (phase_reg == 2'd2) begin
                        state_next = S_FINISH;
                    end else begin
                        state_next = S_GAP;
                        phase_next = phase_reg + 2'd1;
                    end
                end else if (tmo_cnt_reg >= TMO_LAST) begin
                    state_next = S_FAULT;
                end
            end
            S_HOLD: begin
                // A done edge seen while paused is kept and acted on back in RUN.
                pend_next = pend_reg | done_rise;
                if (!pause) state_next = S_RUN;
            end
            S_FINISH: begin
                state_next = (LOOP != 0) ? S_GAP : S_IDLE;
                phase_next = 2'd0;
            end
            S_FAULT: state_next = S_FAULT;
            default: begin
                state_next = S_IDLE;
                phase_next = 2'd0;
            end
        endcase
        if (abort) begin
            state_next = S_IDLE;
            phase_next = 2'd0;
            pend_next  = 1'b0;
        end
    end

    // Counter and output values to be registered. Motors follow cmd only while
    // RUN is held, which gives cmd one cycle of latency after enable rises.
    always_comb begin
        gap_cnt_next = 32'd0;
        tmo_cnt_next = 30'd0;
        motor_next   = 8'd0;
        if (state_reg == S_GAP && state_next == S_GAP) gap_cnt_next = gap_cnt_reg + 32'd1;
        if (active && active_next)
            tmo_cnt_next = (state_reg == S_RUN) ? tmo_cnt_reg + 30'd1 : tmo_cnt_reg;
        if (state_reg == S_RUN && state_next == S_RUN) motor_next = cmd_safe;
    end

    // Each phase controller is enabled for all of its RUN/HOLD time.
    for (genvar gi = 0; gi < 3; gi++) begin : g_en
        assign en_next[gi] = active_next && (phase_next == 2'(gi));
    end

    // State, counters, edge detectors and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            phase_reg    <= 2'd0;
            gap_cnt_reg  <= 32'd0;
            tmo_cnt_reg  <= 30'd0;
            pend_reg     <= 1'b0;
            start_d1_reg <= 1'b0;
            start_d2_reg <= 1'b0;
            done_d1_reg  <= 1'b0;
            done_d2_reg  <= 1'b0;
            motor_reg    <= 8'd0;
            en_reg       <= 3'd0;
            busy_reg     <= 1'b0;
            fault_reg    <= 1'b0;
            seq_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            gap_cnt_reg  <= gap_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            pend_reg     <= pend_next;
            start_d1_reg <= start;
            start_d2_reg <= start_d1_reg;
            // Outside RUN/HOLD both stages load the current level. A done signal
            // that is already high when RUN begins is then not seen as an edge.
            done_d1_reg  <= done_sel;
            done_d2_reg  <= active ? done_d1_reg : done_sel;
            motor_reg    <= motor_next;
            en_reg       <= en_next;
            busy_reg     <= (state_next != S_IDLE) && (state_next != S_FAULT);
            fault_reg    <= (state_next == S_FAULT);
            seq_done_reg <= (state_next == S_FINISH);
        end
    end

    assign {en2, en1, en0}             = en_reg;
    assign {FWD_A, FWD_B, BWD_A, BWD_B} = motor_reg[7:4];
    assign Duty_SelA                   = motor_reg[3:2];
    assign Duty_SelB                   = motor_reg[1:0];
    assign phase                       = phase_reg;
    assign busy                        = busy_reg;
    assign fault                       = fault_reg;
    assign seq_done                    = seq_done_reg;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer (DEADTIME 4, TIMEOUT 50, LOOP 0).
// Expected output words are queued together with the cycle at which they are due.
module tb_drive_sequencer;

    logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [7:0] cmd0 = 8'h00, cmd1 = 8'h00, cmd2 = 8'h00;
    logic       done0 = 1'b0, done1 = 1'b0, done2 = 1'b0;
    logic       en0, en1, en2, FWD_A, FWD_B, BWD_A, BWD_B;
    logic [1:0] Duty_SelA, Duty_SelB, phase;
    logic       busy, fault, seq_done;

    drive_sequencer #(.DEADTIME_CYC(4), .TIMEOUT_CYC(50), .LOOP(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
        .cmd0(cmd0), .cmd1(cmd1), .cmd2(cmd2),
        .done0(done0), .done1(done1), .done2(done2),
        .en0(en0), .en1(en1), .en2(en2),
        .FWD_A(FWD_A), .FWD_B(FWD_B), .BWD_A(BWD_A), .BWD_B(BWD_B),
        .Duty_SelA(Duty_SelA), .Duty_SelB(Duty_SelB),
        .phase(phase), .busy(busy), .fault(fault), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];
    int  vectors = 0, miscompares = 0, cycle = 0;

    // Output word: {en0,en1,en2, FWD_A,FWD_B,BWD_A,BWD_B,DutyA,DutyB, phase, busy, fault, seq_done}
    function automatic logic [15:0] observed();
        return {en0, en1, en2, FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB,
                phase, busy, fault, seq_done};
    endfunction

    function automatic logic [15:0] mk(logic [2:0] en, logic [7:0] mot, logic [1:0] ph,
                                       logic b, logic f, logic s);
        return {en, mot, ph, b, f, s};
    endfunction

    // Reference shoot-through guard.
    function automatic logic [7:0] guard(logic [7:0] c);
        logic [7:0] g;
        g = c;
        if (c[7] && c[5]) begin g[7] = 1'b0; g[5] = 1'b0; end
        if (c[6] && c[4]) begin g[6] = 1'b0; g[4] = 1'b0; end
        return g;
    endfunction

    task automatic compare(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_at(int lat, string tag, logic [15:0] exp);
        sb.push_back('{cycle + lat, tag, exp});
    endtask

    task automatic tick();
        int i;
        @(posedge clk);
        @(negedge clk);
        cycle++;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cycle) begin
                $display("cycle %0d %s observed=%h expected=%h", cycle, sb[i].tag,
                         observed(), sb[i].exp);
                compare(sb[i].tag, {16'd0, observed()}, {16'd0, sb[i].exp});
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        compare("reset_state", {16'd0, observed()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: start rise, then the dead-time, then enable, then the command.
        cmd0  = 8'h9A;
        start = 1'b1;
        expect_at(1, "t1_idle", mk(3'b000, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
        expect_at(2, "t1_busy", mk(3'b000, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0));
        expect_at(5, "t1_gap_end", mk(3'b000, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0));
        expect_at(6, "t1_en0", mk(3'b100, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0));
        expect_at(7, "t1_cmd0", mk(3'b100, guard(8'h9A), 2'd0, 1'b1, 1'b0, 1'b0));
        ticks(7);
        start = 1'b0;

        // 2 and 5: step through the phases. Phase 2 gets the both-directions cmd F0.
        cmd1  = 8'h66;
        cmd2  = 8'hF0;
        done0 = 1'b1;
        expect_at(1, "t2_p0_hold", mk(3'b100, guard(8'h9A), 2'd0, 1'b1, 1'b0, 1'b0));
        expect_at(2, "t2_gap1", mk(3'b000, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0));
        expect_at(5, "t2_gap1_end", mk(3'b000, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0));
        expect_at(6, "t2_en1", mk(3'b010, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0));
        expect_at(7, "t2_cmd1", mk(3'b010, guard(8'h66), 2'd1, 1'b1, 1'b0, 1'b0));
        tick();
        done0 = 1'b0;
        ticks(6);
        done1 = 1'b1;
        expect_at(2, "t2_gap2", mk(3'b000, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0));
        expect_at(6, "t2_en2", mk(3'b001, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0));
        expect_at(7, "t5_f0_guard", mk(3'b001, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0));
        tick();
        done1 = 1'b0;
        ticks(6);
        cmd2 = 8'hF5;
        expect_at(1, "t5_f5_duty", mk(3'b001, 8'h05, 2'd2, 1'b1, 1'b0, 1'b0));
        tick();
        done2 = 1'b1;
        expect_at(1, "t2_p2_hold", mk(3'b001, 8'h05, 2'd2, 1'b1, 1'b0, 1'b0));
        expect_at(2, "t2_seq_done", mk(3'b000, 8'h00, 2'd2, 1'b1, 1'b0, 1'b1));
        expect_at(3, "t2_idle", mk(3'b000, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
        expect_at(4, "t2_idle_stay", mk(3'b000, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
        tick();
        done2 = 1'b0;
        ticks(3);

        // 3 and 4: pause for 10 cycles inside RUN, then let the phase time out.
        start = 1'b1;
        expect_at(6, "t3_en0", mk(3'b100, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0));
        ticks(6);
        start = 1'b0;
        expect_at(3, "t3_run", mk(3'b100, guard(8'h9A), 2'd0, 1'b1, 1'b0, 1'b0));
        ticks(3);
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expect_at(1, "t3_hold", mk(3'b100, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0));
            tick();
        end
        pause = 1'b0;
        expect_at(1, "t3_resume_off", mk(3'b100, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0));
        expect_at(2, "t3_resume", mk(3'b100, guard(8'h9A), 2'd0, 1'b1, 1'b0, 1'b0));
        ticks(2);
        // 6 RUN cycles so far, so 44 more come before the timeout fault.
        expect_at(44, "t4_last_run", mk(3'b100, guard(8'h9A), 2'd0, 1'b1, 1'b0, 1'b0));
        expect_at(45, "t4_fault", mk(3'b000, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0));
        ticks(45);
        start = 1'b1;
        expect_at(4, "t4_start_ignored", mk(3'b000, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0));
        ticks(4);
        start = 1'b0;
        abort = 1'b1;
        expect_at(1, "t4_abort", mk(3'b000, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
        tick();
        abort = 1'b0;
        expect_at(2, "t4_idle", mk(3'b000, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
        ticks(2);

        // 6: done1 is already high when phase 1 starts; pause during GAP; reset mid-phase.
        start = 1'b1;
        expect_at(6, "t6_en0", mk(3'b100, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0));
        ticks(6);
        start = 1'b0;
        done1 = 1'b1;
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        expect_at(1, "t6_gap1", mk(3'b000, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0));
        tick();
        pause = 1'b1;
        expect_at(2, "t6_gap_pause", mk(3'b000, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0));
        expect_at(4, "t6_en1", mk(3'b010, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0));
        ticks(2);
        pause = 1'b0;
        ticks(2);
        expect_at(8, "t6_done_held", mk(3'b010, guard(8'h66), 2'd1, 1'b1, 1'b0, 1'b0));
        ticks(8);
        #2 rst_n = 1'b0;
        #1 compare("t6_async_reset", {16'd0, observed()}, 32'd0);
        $display("async reset observed=%h expected=0000", observed());
        compare("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
